// File: rtl/alarm_pkg.sv
// Shared constants, state encoding and helpers
// for the multi-slot alarm scheduler.
package alarm_pkg;

  localparam int TIME_W = 8;
  localparam int SNZ_W = 4;
  localparam logic [TIME_W-1:0] HR_MAX = 8'd23;
  localparam logic [TIME_W-1:0] MIN_MAX = 8'd59;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RINGING = 2'b01,
    ST_SNOOZED = 2'b10
  } state_t;

  function automatic logic [TIME_W-1:0] sat_inc(
    input logic [TIME_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/alarm_match.sv
// Compares every armed slot with the current time;
// lowest matching index wins.
module alarm_match
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS = 4,
  parameter int IDX_W = 2
) (
  input  logic [NUM_ALARMS-1:0][TIME_W-1:0] hrs,
  input  logic [NUM_ALARMS-1:0][TIME_W-1:0] mins,
  input  logic [NUM_ALARMS-1:0]             armed,
  input  logic [TIME_W-1:0]                 currHour,
  input  logic [TIME_W-1:0]                 currMin,
  output logic                              hit,
  output logic [IDX_W-1:0]                  hitIdx
);

  always_comb begin
    hit = 1'b0;
    hitIdx = '0;
    // Scan downward so the lowest index is written last.
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (armed[i] && hrs[i] == currHour &&
          mins[i] == currMin) begin
        hit = 1'b1;
        hitIdx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/alarm_scheduler.sv
// Multi-slot alarm controller: slot table, match,
// and ringing/snooze/timeout state machine.
module alarm_scheduler
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS = 4,
  parameter int IDX_W = 2,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3,
  parameter int RING_TIMEOUT_MIN = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  minTick,
  input  logic [TIME_W-1:0]     currHour,
  input  logic [TIME_W-1:0]     currMin,
  input  logic                  wrEn,
  input  logic [IDX_W-1:0]      wrIdx,
  input  logic [TIME_W-1:0]     wrHr,
  input  logic [TIME_W-1:0]     wrMin,
  input  logic                  wrArm,
  input  logic                  snooze,
  input  logic                  stop,
  input  logic                  motionDetected,
  output logic                  alarmOut,
  output logic [IDX_W-1:0]      activeIdx,
  output logic [1:0]            state,
  output logic [SNZ_W-1:0]      snoozeCnt,
  output logic [NUM_ALARMS-1:0] armedMask
);

  logic [NUM_ALARMS-1:0][TIME_W-1:0] hr_q;
  logic [NUM_ALARMS-1:0][TIME_W-1:0] min_q;
  logic                 wr_ok;
  logic                 kill;
  logic                 hit;
  logic [IDX_W-1:0]     hit_idx;
  state_t               st_q;
  state_t               st_d;
  logic [IDX_W-1:0]     idx_d;
  logic [SNZ_W-1:0]     cnt_d;
  logic [TIME_W-1:0]    ring_q;
  logic [TIME_W-1:0]    ring_d;
  logic [TIME_W-1:0]    snz_q;
  logic [TIME_W-1:0]    snz_d;
  logic [TIME_W-1:0]    ring_inc;
  logic [TIME_W-1:0]    snz_inc;

  assign wr_ok = wrEn && wrHr <= HR_MAX &&
                 wrMin <= MIN_MAX &&
                 int'(wrIdx) < NUM_ALARMS;
  assign kill = wr_ok && !wrArm &&
                wrIdx == activeIdx;
  assign state = st_q;
  assign ring_inc = sat_inc(ring_q);
  assign snz_inc = sat_inc(snz_q);

  alarm_match #(
    .NUM_ALARMS(NUM_ALARMS),
    .IDX_W(IDX_W)
  ) u_match (
    .hrs(hr_q),
    .mins(min_q),
    .armed(armedMask),
    .currHour(currHour),
    .currMin(currMin),
    .hit(hit),
    .hitIdx(hit_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hr_q <= '0;
      min_q <= '0;
      armedMask <= '0;
    end else if (wr_ok) begin
      hr_q[wrIdx] <= wrHr;
      min_q[wrIdx] <= wrMin;
      armedMask[wrIdx] <= wrArm;
    end
  end

  always_comb begin
    st_d = st_q;
    idx_d = activeIdx;
    cnt_d = snoozeCnt;
    ring_d = ring_q;
    snz_d = snz_q;
    case (st_q)
      ST_IDLE: begin
        if (minTick && hit) begin
          st_d = ST_RINGING;
          idx_d = hit_idx;
          cnt_d = '0;
        end
      end
      ST_RINGING: begin
        if (kill || stop || motionDetected) begin
          st_d = ST_IDLE;
        end else if (snooze &&
            snoozeCnt < SNZ_W'(MAX_SNOOZE)) begin
          st_d = ST_SNOOZED;
          cnt_d = snoozeCnt + 1'b1;
        end else if (minTick) begin
          ring_d = ring_inc;
          if (ring_inc >= TIME_W'(RING_TIMEOUT_MIN))
            st_d = ST_IDLE;
        end
      end
      ST_SNOOZED: begin
        if (kill || stop) begin
          st_d = ST_IDLE;
        end else if (minTick && hit) begin
          st_d = ST_RINGING;
          idx_d = hit_idx;
          cnt_d = '0;
        end else if (minTick) begin
          snz_d = snz_inc;
          if (snz_inc >= TIME_W'(SNOOZE_MIN))
            st_d = ST_RINGING;
        end
      end
      default: st_d = ST_IDLE;
    endcase
    // Any state change restarts both minute timers.
    if (st_d != st_q) begin
      ring_d = '0;
      snz_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q <= ST_IDLE;
      alarmOut <= 1'b0;
      activeIdx <= '0;
      snoozeCnt <= '0;
      ring_q <= '0;
      snz_q <= '0;
    end else begin
      st_q <= st_d;
      alarmOut <= (st_d == ST_RINGING);
      activeIdx <= idx_d;
      snoozeCnt <= cnt_d;
      ring_q <= ring_d;
      snz_q <= snz_d;
    end
  end

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed vector bench for alarm_scheduler
// with hand-written snooze/timeout/reset sequences.
module tb_alarm_scheduler;

  logic       clk;
  logic       reset;
  logic       minTick;
  logic [7:0] currHour;
  logic [7:0] currMin;
  logic       wrEn;
  logic [1:0] wrIdx;
  logic [7:0] wrHr;
  logic [7:0] wrMin;
  logic       wrArm;
  logic       snooze;
  logic       stop;
  logic       motionDetected;
  logic       alarmOut;
  logic [1:0] activeIdx;
  logic [1:0] state;
  logic [3:0] snoozeCnt;
  logic [3:0] armedMask;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       tick;
    logic [7:0] hr;
    logic [7:0] mn;
    logic       we;
    logic [1:0] widx;
    logic [7:0] whr;
    logic [7:0] wmn;
    logic       warm;
    logic       snz;
    logic       stp;
    logic       mot;
    logic       e_out;
    logic [1:0] e_st;
    logic [1:0] e_idx;
    logic [3:0] e_cnt;
    logic [3:0] e_mask;
  } vec_t;

  vec_t vecs[19];

  alarm_scheduler dut (
    .clk(clk),
    .reset(reset),
    .minTick(minTick),
    .currHour(currHour),
    .currMin(currMin),
    .wrEn(wrEn),
    .wrIdx(wrIdx),
    .wrHr(wrHr),
    .wrMin(wrMin),
    .wrArm(wrArm),
    .snooze(snooze),
    .stop(stop),
    .motionDetected(motionDetected),
    .alarmOut(alarmOut),
    .activeIdx(activeIdx),
    .state(state),
    .snoozeCnt(snoozeCnt),
    .armedMask(armedMask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic o,
                         input logic [1:0] s,
                         input logic [1:0] i,
                         input logic [3:0] c,
                         input logic [3:0] m);
    chk({tag, ".alarmOut"}, {7'd0, alarmOut}, {7'd0, o});
    chk({tag, ".state"}, {6'd0, state}, {6'd0, s});
    chk({tag, ".activeIdx"}, {6'd0, activeIdx}, {6'd0, i});
    chk({tag, ".snoozeCnt"}, {4'd0, snoozeCnt}, {4'd0, c});
    chk({tag, ".armedMask"}, {4'd0, armedMask}, {4'd0, m});
  endtask

  task automatic idle_inputs();
    minTick = 0;
    wrEn = 0;
    snooze = 0;
    stop = 0;
    motionDetected = 0;
  endtask

  task automatic apply(input vec_t v);
    minTick = v.tick;
    currHour = v.hr;
    currMin = v.mn;
    wrEn = v.we;
    wrIdx = v.widx;
    wrHr = v.whr;
    wrMin = v.wmn;
    wrArm = v.warm;
    snooze = v.snz;
    stop = v.stp;
    motionDetected = v.mot;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic cyc(input logic t, input logic [7:0] h,
                     input logic [7:0] m, input logic s);
    minTick = t;
    currHour = h;
    currMin = m;
    snooze = s;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    vecs[0]  = '{0,0,0,   1,1,7,30,1, 0,0,0, 0,0,0,0,4'b0010};
    vecs[1]  = '{1,7,30,  0,0,0,0,0,  0,0,0, 1,1,1,0,4'b0010};
    vecs[2]  = '{0,0,0,   0,0,0,0,0,  0,1,0, 0,0,1,0,4'b0010};
    vecs[3]  = '{0,0,0,   1,0,6,0,1,  0,0,0, 0,0,1,0,4'b0011};
    vecs[4]  = '{0,0,0,   1,2,6,0,1,  0,0,0, 0,0,1,0,4'b0111};
    vecs[5]  = '{1,6,0,   0,0,0,0,0,  0,0,0, 1,1,0,0,4'b0111};
    vecs[6]  = '{0,0,0,   0,0,0,0,0,  1,1,0, 0,0,0,0,4'b0111};
    vecs[7]  = '{0,0,0,   1,3,24,0,1, 0,0,0, 0,0,0,0,4'b0111};
    vecs[8]  = '{0,0,0,   1,3,5,60,1, 0,0,0, 0,0,0,0,4'b0111};
    vecs[9]  = '{1,6,0,   0,0,0,0,0,  0,0,0, 1,1,0,0,4'b0111};
    vecs[10] = '{0,0,0,   0,0,0,0,0,  1,0,0, 0,2,0,1,4'b0111};
    vecs[11] = '{0,0,0,   0,0,0,0,0,  0,0,1, 0,2,0,1,4'b0111};
    vecs[12] = '{0,0,0,   0,0,0,0,0,  1,0,0, 0,2,0,1,4'b0111};
    vecs[13] = '{0,0,0,   1,3,6,1,1,  0,0,0, 0,2,0,1,4'b1111};
    vecs[14] = '{1,6,1,   0,0,0,0,0,  0,0,0, 1,1,3,0,4'b1111};
    vecs[15] = '{0,0,0,   1,3,6,2,1,  0,0,0, 1,1,3,0,4'b1111};
    vecs[16] = '{0,0,0,   1,3,6,2,0,  0,0,0, 0,0,3,0,4'b0111};
    vecs[17] = '{1,7,30,  1,1,7,30,0, 0,0,0, 1,1,1,0,4'b0101};
    vecs[18] = '{0,0,0,   0,0,0,0,0,  0,1,0, 0,0,1,0,4'b0101};

    reset = 0;
    currHour = 0;
    currMin = 0;
    wrIdx = 0;
    wrHr = 0;
    wrMin = 0;
    wrArm = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 4'b0000);
    reset = 1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 19; k++) begin
      apply(vecs[k]);
      chk_all($sformatf("vec%0d", k), vecs[k].e_out,
              vecs[k].e_st, vecs[k].e_idx,
              vecs[k].e_cnt, vecs[k].e_mask);
    end

    // Three full snooze rounds on slot0 (06:00).
    cyc(1, 6, 0, 0);
    chk_all("ring0", 1, 1, 0, 0, 4'b0101);
    for (int r = 1; r <= 3; r++) begin
      cyc(0, 12, 0, 1);
      chk_all($sformatf("snz%0d", r), 0, 2, 0,
              4'(r), 4'b0101);
      for (int t = 0; t < 4; t++) cyc(1, 12, 0, 0);
      chk($sformatf("snz%0d.wait", r), {6'd0, state}, 8'd2);
      cyc(1, 12, 0, 0);
      chk_all($sformatf("rering%0d", r), 1, 1, 0,
              4'(r), 4'b0101);
    end
    cyc(0, 12, 0, 1);
    chk_all("snz_max", 1, 1, 0, 3, 4'b0101);

    // Ten unattended minutes end the session.
    for (int t = 0; t < 9; t++) cyc(1, 12, 0, 0);
    chk("timeout.pre", {6'd0, state}, 8'd1);
    cyc(1, 12, 0, 0);
    chk_all("timeout", 0, 0, 0, 3, 4'b0101);

    // Asynchronous reset in the middle of a ring.
    cyc(1, 6, 0, 0);
    chk("rst.ring", {7'd0, alarmOut}, 8'd1);
    #2 reset = 0;
    #1;
    chk_all("rst.async", 0, 0, 0, 0, 4'b0000);
    #1 reset = 1;
    @(posedge clk);
    #1;
    cyc(1, 0, 0, 0);
    chk_all("rst.t0000", 0, 0, 0, 0, 4'b0000);
    cyc(1, 6, 0, 0);
    chk_all("rst.t0600", 0, 0, 0, 0, 4'b0000);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
